// File: rtl/i2c_pkg.sv
// Shared constants for the I2C slave target: FSM state codes and bus-level ACK values.
package i2c_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ADDR     = 3'd1;
    localparam state_t ST_ADDR_ACK = 3'd2;
    localparam state_t ST_WR_DATA  = 3'd3;
    localparam state_t ST_WR_ACK   = 3'd4;
    localparam state_t ST_RD_DATA  = 3'd5;
    localparam state_t ST_RD_ACK   = 3'd6;
    localparam state_t ST_IGNORE   = 3'd7;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C line plus registered rise/fall pulses.
// The level output is aligned with the pulses, so both can be combined in the same cycle.
module i2c_line_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync;

    // Idle-high reset value keeps a released bus from looking like an edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {3{RESET_VAL}};
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[1:0], line};
            rise <= sync[1] & ~sync[2];
            fall <= ~sync[1] & sync[2];
        end
    end

    assign level = sync[2];

endmodule

// File: rtl/i2c_slave_target.sv
// 7-bit-address I2C slave with a small register file; oversamples SCL/SDA on the core
// clock and drives SDA open-drain through sda_oe_o.
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h10,
    parameter int         MEM_DEPTH  = 4,
    parameter int         AW         = 2
) (
    input  logic          i2c_core_clk_i,
    input  logic          i2c_core_rst_i,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe_o,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [7:0]    mem_wdata_i,
    output logic          rx_valid_o,
    output logic [7:0]    rx_data_o,
    output logic          busy_o,
    output logic          start_det_o,
    output logic          stop_det_o,
    output logic          nack_o
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.RESET_VAL(1'b1)) u_scl_sync (
        .clk   (i2c_core_clk_i),
        .rst   (i2c_core_rst_i),
        .line  (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_sync #(.RESET_VAL(1'b1)) u_sda_sync (
        .clk   (i2c_core_clk_i),
        .rst   (i2c_core_rst_i),
        .line  (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start_ev, stop_ev;
    assign start_ev = sda_fall & scl_lvl;
    assign stop_ev  = sda_rise & scl_lvl;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;
    logic [6:0]    tx;
    logic [AW-1:0] ptr;
    logic          rw;
    logic          phase;

    logic [7:0]    byte_in;
    logic [7:0]    rd_byte;
    logic          wr_en;
    logic [7:0]    mem [MEM_DEPTH];

    assign byte_in = {shreg, sda_lvl};
    assign rd_byte = mem[ptr];
    assign wr_en   = ~start_ev & ~stop_ev & scl_rise & (state == ST_WR_DATA) & (bit_cnt == 3'd7);

    // The I2C write is issued last so it overrides a same-address preload in the same cycle.
    always_ff @(posedge i2c_core_clk_i) begin
        if (mem_we_i) begin
            mem[mem_addr_i] <= mem_wdata_i;
        end
        if (wr_en) begin
            mem[ptr] <= byte_in;
        end
    end

    // phase marks the second SCL fall of an ACK slot (ACK driven -> ACK finished),
    // and in RD_ACK that the master ACKed and the next byte must be launched.
    always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
        if (i2c_core_rst_i) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shreg       <= 7'd0;
            tx          <= 7'd0;
            ptr         <= '0;
            rw          <= 1'b0;
            phase       <= 1'b0;
            sda_oe_o    <= 1'b0;
            rx_valid_o  <= 1'b0;
            rx_data_o   <= 8'd0;
            busy_o      <= 1'b0;
            start_det_o <= 1'b0;
            stop_det_o  <= 1'b0;
            nack_o      <= 1'b0;
        end else begin
            rx_valid_o  <= 1'b0;
            start_det_o <= 1'b0;
            stop_det_o  <= 1'b0;
            nack_o      <= 1'b0;
            if (start_ev) begin
                state       <= ST_ADDR;
                bit_cnt     <= 3'd0;
                ptr         <= '0;
                phase       <= 1'b0;
                sda_oe_o    <= 1'b0;
                busy_o      <= 1'b0;
                start_det_o <= 1'b1;
            end else if (stop_ev) begin
                state      <= ST_IDLE;
                sda_oe_o   <= 1'b0;
                busy_o     <= 1'b0;
                stop_det_o <= 1'b1;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_in[7:1] == SLAVE_ADDR) begin
                                    state  <= ST_ADDR_ACK;
                                    rw     <= byte_in[RW_BIT];
                                    busy_o <= 1'b1;
                                    phase  <= 1'b0;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe_o <= ~I2C_ACK;
                                phase    <= 1'b1;
                            end else begin
                                phase   <= 1'b0;
                                bit_cnt <= 3'd0;
                                if (rw) begin
                                    tx       <= rd_byte[6:0];
                                    sda_oe_o <= ~rd_byte[7];
                                    state    <= ST_RD_DATA;
                                end else begin
                                    sda_oe_o <= 1'b0;
                                    state    <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_in[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data_o  <= byte_in;
                                rx_valid_o <= 1'b1;
                                ptr        <= ptr + AW'(1);
                                phase      <= 1'b0;
                                state      <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe_o <= ~I2C_ACK;
                                phase    <= 1'b1;
                            end else begin
                                sda_oe_o <= 1'b0;
                                phase    <= 1'b0;
                                bit_cnt  <= 3'd0;
                                state    <= ST_WR_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe_o <= 1'b0;
                                phase    <= 1'b0;
                                state    <= ST_RD_ACK;
                            end else begin
                                bit_cnt  <= bit_cnt + 3'd1;
                                tx       <= {tx[5:0], 1'b0};
                                sda_oe_o <= ~tx[6];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_lvl == I2C_ACK) begin
                                ptr   <= ptr + AW'(1);
                                phase <= 1'b1;
                            end else begin
                                nack_o   <= 1'b1;
                                sda_oe_o <= 1'b0;
                                state    <= ST_IGNORE;
                            end
                        end else if (scl_fall && phase) begin
                            tx       <= rd_byte[6:0];
                            sda_oe_o <= ~rd_byte[7];
                            bit_cnt  <= 3'd0;
                            phase    <= 1'b0;
                            state    <= ST_RD_DATA;
                        end
                    end
                    default: begin
                        sda_oe_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: a bit-banged I2C master, a table of transactions, corner
// sequences and randomized traffic checked against a byte-level memory model.
module tb_i2c_slave_target;

    localparam int Q = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m_low = 1'b0;
    logic       mem_we = 1'b0;
    logic [1:0] mem_addr = 2'd0;
    logic [7:0] mem_wdata = 8'd0;

    logic       sda_bus;
    logic       sda_oe;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       start_det;
    logic       stop_det;
    logic       nack;

    assign sda_bus = ~(sda_m_low | sda_oe);

    i2c_slave_target dut (
        .i2c_core_clk_i (clk),
        .i2c_core_rst_i (rst),
        .scl_i          (scl),
        .sda_i          (sda_bus),
        .sda_oe_o       (sda_oe),
        .mem_we_i       (mem_we),
        .mem_addr_i     (mem_addr),
        .mem_wdata_i    (mem_wdata),
        .rx_valid_o     (rx_valid),
        .rx_data_o      (rx_data),
        .busy_o         (busy),
        .start_det_o    (start_det),
        .stop_det_o     (stop_det),
        .nack_o         (nack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    int n_start = 0, n_stop = 0, n_rx = 0, n_nack = 0, n_oe_cyc = 0, n_busy_cyc = 0;
    logic [7:0] rx_log [256];
    logic [7:0] mem_m [4];

    always @(negedge clk) begin
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
        if (nack)      n_nack++;
        if (sda_oe)    n_oe_cyc++;
        if (busy)      n_busy_cyc++;
        if (rx_valid) begin
            rx_log[n_rx % 256] = rx_data;
            n_rx++;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        wait_clk(1);
        mem_we    = 1'b0;
        mem_m[a]  = d;
    endtask

    task automatic i2c_start();
        sda_m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic i2c_rep_start();
        wait_clk(Q);
        sda_m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        sda_m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m_low = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic bit_out(input logic b);
        wait_clk(Q);
        sda_m_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        scl = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        wait_clk(Q);
        sda_m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        b = sda_bus;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_in(s);
            b[i] = s;
        end
        bit_out(~ack);
    endtask

    // One framed transaction (START, address, data, STOP) with all per-transaction checks.
    task automatic run_txn(input string tag, input logic rd, input logic [7:0] addr, input int len,
                           input logic [39:0] wdata, input logic exp_ack, input logic [39:0] exp_rd);
        int   s_start = n_start, s_stop = n_stop, s_rx = n_rx, s_nack = n_nack;
        int   s_oe = n_oe_cyc, s_busy = n_busy_cyc;
        logic ack, a;
        logic [7:0] b;
        i2c_start();
        write_byte(addr, ack);
        check({tag, " addr_ack"}, ack, exp_ack);
        if (ack) begin
            check({tag, " busy_mid"}, busy, 1);
            for (int k = 0; k < len; k++) begin
                if (!rd) begin
                    write_byte(wdata[8*k +: 8], a);
                    check({tag, " data_ack"}, a, 1);
                end else begin
                    read_byte(b, k != len - 1);
                    check($sformatf("%s rd_byte%0d", tag, k), b, exp_rd[8*k +: 8]);
                end
            end
        end
        i2c_stop();
        wait_clk(4);
        check({tag, " start_cnt"}, n_start - s_start, 1);
        check({tag, " stop_cnt"}, n_stop - s_stop, 1);
        check({tag, " busy_end"}, busy, 0);
        if (ack && !rd) begin
            check({tag, " rx_cnt"}, n_rx - s_rx, len);
            for (int k = 0; k < len; k++)
                check($sformatf("%s rx_data%0d", tag, k), rx_log[(s_rx + k) % 256], wdata[8*k +: 8]);
        end
        if (ack && rd) check({tag, " nack_cnt"}, n_nack - s_nack, 1);
        if (!ack) begin
            check({tag, " oe_idle"}, n_oe_cyc - s_oe, 0);
            check({tag, " busy_idle"}, n_busy_cyc - s_busy, 0);
            check({tag, " rx_none"}, n_rx - s_rx, 0);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [7:0]  addr;
        int          len;
        logic [39:0] wdata;
        logic        exp_ack;
        logic [39:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic        ack, a;
        logic [7:0]  b;
        logic [39:0] wd, er;
        logic        saw;
        int          s_start, s_stop, s_nack;

        vecs[0] = '{1'b0, 8'h20, 1, 40'h00_0000_0012, 1'b1, 40'h0};
        vecs[1] = '{1'b1, 8'h21, 1, 40'h0, 1'b1, 40'h00_0000_0012};
        vecs[2] = '{1'b0, 8'h40, 1, 40'h00_0000_0077, 1'b0, 40'h0};
        vecs[3] = '{1'b1, 8'h41, 1, 40'h0, 1'b0, 40'h0};
        vecs[4] = '{1'b0, 8'h20, 5, 40'h05_0403_0201, 1'b1, 40'h0};
        vecs[5] = '{1'b1, 8'h21, 4, 40'h0, 1'b1, 40'h00_0403_0205};
        vecs[6] = '{1'b1, 8'h21, 5, 40'h0, 1'b1, 40'h05_0403_0205};

        wait_clk(5);
        check("rst sda_oe", sda_oe, 0);
        check("rst rx_valid", rx_valid, 0);
        check("rst rx_data", rx_data, 0);
        check("rst busy", busy, 0);
        check("rst start_det", start_det, 0);
        check("rst stop_det", stop_det, 0);
        check("rst nack", nack, 0);
        rst = 1'b0;
        wait_clk(5);

        for (int v = 0; v < 7; v++) begin
            run_txn($sformatf("vec%0d", v), vecs[v].rd, vecs[v].addr, vecs[v].len,
                    vecs[v].wdata, vecs[v].exp_ack, vecs[v].exp_rd);
            if (!vecs[v].rd && vecs[v].exp_ack)
                for (int k = 0; k < vecs[v].len; k++) mem_m[k % 4] = vecs[v].wdata[8*k +: 8];
        end

        preload(2'd0, 8'ha3);
        preload(2'd1, 8'h11);
        preload(2'd2, 8'h09);
        run_txn("preload_rd", 1'b1, 8'h21, 3, 40'h0, 1'b1, 40'h00_0009_11a3);

        $display("[TB] repeated START sequence");
        preload(2'd0, 8'h77);
        s_start = n_start;
        s_stop  = n_stop;
        s_nack  = n_nack;
        i2c_start();
        write_byte(8'h20, ack);
        check("rs wr_addr_ack", ack, 1);
        i2c_rep_start();
        write_byte(8'h21, ack);
        check("rs rd_addr_ack", ack, 1);
        read_byte(b, 1'b0);
        check("rs rd_byte", b, mem_m[0]);
        i2c_stop();
        wait_clk(4);
        check("rs start_cnt", n_start - s_start, 2);
        check("rs stop_cnt", n_stop - s_stop, 1);
        check("rs nack_cnt", n_nack - s_nack, 1);

        $display("[TB] preload vs I2C write collision");
        i2c_start();
        write_byte(8'h20, ack);
        check("col addr_ack", ack, 1);
        mem_addr  = 2'd0;
        mem_wdata = 8'hee;
        mem_we    = 1'b1;
        saw       = 1'b0;
        fork
            write_byte(8'h5a, a);
            begin
                for (int i = 0; i < 2000 && !saw; i++) begin
                    @(negedge clk);
                    if (rx_valid) saw = 1'b1;
                end
                mem_we = 1'b0;
            end
        join
        check("col rx_seen", saw, 1);
        check("col data_ack", a, 1);
        i2c_stop();
        mem_m[0] = 8'h5a;
        run_txn("col_rd", 1'b1, 8'h21, 1, 40'h0, 1'b1, {32'h0, 8'h5a});

        $display("[TB] reset during read");
        preload(2'd0, 8'h00);
        i2c_start();
        write_byte(8'h21, ack);
        check("rr addr_ack", ack, 1);
        wait_clk(Q);
        check("rr oe_before", sda_oe, 1);
        rst = 1'b1;
        #1;
        check("rr oe_async", sda_oe, 0);
        check("rr busy_async", busy, 0);
        wait_clk(3);
        sda_m_low = 1'b0;
        rst = 1'b0;
        wait_clk(4);
        scl = 1'b1;
        wait_clk(2 * Q);
        run_txn("rr_recover", 1'b0, 8'h20, 1, {32'h0, 8'h3c}, 1'b1, 40'h0);
        mem_m[0] = 8'h3c;

        $display("[TB] randomized traffic");
        for (int t = 0; t < 16; t++) begin
            int kind = $urandom_range(0, 3);
            int len  = $urandom_range(1, 5);
            wd = {$urandom, 8'($urandom)};
            er = '0;
            case (kind)
                0: preload(2'($urandom_range(0, 3)), 8'($urandom));
                1: begin
                    run_txn($sformatf("rnd%0d_wr", t), 1'b0, 8'h20, len, wd, 1'b1, 40'h0);
                    for (int k = 0; k < len; k++) mem_m[k % 4] = wd[8*k +: 8];
                end
                2: begin
                    for (int k = 0; k < len; k++) er[8*k +: 8] = mem_m[k % 4];
                    run_txn($sformatf("rnd%0d_rd", t), 1'b1, 8'h21, len, 40'h0, 1'b1, er);
                end
                default: begin
                    logic [6:0] ad = 7'($urandom_range(0, 127));
                    if (ad == 7'h10) ad = 7'h11;
                    run_txn($sformatf("rnd%0d_miss", t), 1'($urandom), {ad, 1'($urandom)}, len,
                            wd, 1'b0, 40'h0);
                end
            endcase
        end

        for (int k = 0; k < 4; k++) er[8*k +: 8] = mem_m[k];
        run_txn("final_rd", 1'b1, 8'h21, 4, 40'h0, 1'b1, {8'h0, er[31:0]});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
